// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU execute stage: default widths, opcode
// encodings, FSM state encoding and a small signed-overflow helper.
//   DEF_DATA_W    operand/result width (signed two's complement)
//   DEF_ADDR_W    register address width
//   DEF_MUL_ITERS shift-add iterations of the multiplier (equals data width)
package alu_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 3;
    localparam int DEF_MUL_ITERS = 8;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_SLT   = 3'd5;
    localparam logic [2:0] OP_MUL   = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_MUL_BUSY = 1'b1
    } state_t;

    // Two's complement addition overflows when both addends share a sign and
    // the sum's sign differs. For subtraction pass the inverted sign of b.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_exec_stage_seq_multiplier.sv
// seq_multiplier
// Iterative shift-add multiplier returning the low DATA_W bits of the
// product. The low half of a two's complement product is identical to the
// low half of the unsigned product of the same bit patterns, so a plain
// unsigned shift-add gives the correct signed wrapped result.
// Ports:
//   clk      rising-edge clock
//   reset_n  async active-low reset
//   start    begin a new multiply; a/b are latched on this edge
//   a, b     operands (bit patterns)
//   done     high during the cycle whose closing edge performs the final
//            iteration; product is valid in that same cycle
//   product  low DATA_W bits of a*b (combinational, qualified by done)
module seq_multiplier #(
    parameter int DATA_W = 8,
    parameter int ITERS  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(ITERS + 1);

    logic              running;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // Exposing the last partial sum combinationally lets the parent register
    // the result on the same edge the counter reaches ITERS.
    assign done    = running && (cnt == CNT_W'(ITERS - 1));
    assign product = acc_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            mcand   <= a;
            mplier  <= b;
            acc     <= '0;
        end else if (running) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage
// Execute stage in front of the register file write port. Single-cycle ALU
// ops produce their result on the accepting edge; MUL runs through an
// iterative multiplier and produces its result MUL_ITERS edges later.
// RegWrite is a one-cycle strobe; write_reg/write_data follow one cycle
// later to line up with the register file's internal write delay.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   in_valid/in_ready   operand bundle handshake (accept = valid && ready)
//   op, opa, opb        opcode and signed operands
//   dest, wr_en_in      destination register and write-back enable
//   RegWrite            write strobe to the register file
//   write_reg/data      destination and result, valid the cycle after RegWrite
//   flag_z, flag_v      zero flag, ADD/SUB signed overflow flag
//   busy                multiply in progress (inverse of in_ready)
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MUL_ITERS = DEF_MUL_ITERS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               op,
    input  logic signed [DATA_W-1:0] opa,
    input  logic signed [DATA_W-1:0] opb,
    input  logic [ADDR_W-1:0]        dest,
    input  logic                     wr_en_in,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        write_reg,
    output logic [DATA_W-1:0]        write_data,
    output logic                     flag_z,
    output logic                     flag_v,
    output logic                     busy
);

    localparam int MSB = DATA_W - 1;

    state_t state;
    state_t next_state;

    logic              alu_fire;
    logic              mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;
    logic [ADDR_W-1:0] mul_dest;
    logic              mul_wr_en;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] alu_result;
    logic              alu_ovf;

    // Result waiting to be presented on write_reg/write_data one cycle
    // after its strobe.
    logic [DATA_W-1:0] res_q;
    logic [ADDR_W-1:0] dest_q;

    assign alu_fire  = in_valid && in_ready && (op != OP_MUL);
    assign mul_start = in_valid && in_ready && (op == OP_MUL);
    assign busy      = ~in_ready;

    seq_multiplier #(
        .DATA_W (DATA_W),
        .ITERS  (MUL_ITERS)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (opa),
        .b       (opb),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && (op == OP_MUL)) begin
                    next_state = S_MUL_BUSY;
                end
            end
            S_MUL_BUSY: begin
                if (mul_done) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    assign sum  = opa + opb;
    assign diff = opa - opb;

    // MUL never goes through this path; it falls to the zero default.
    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_result = sum;
                alu_ovf    = signed_ovf(opa[MSB], opb[MSB], sum[MSB]);
            end
            OP_SUB: begin
                alu_result = diff;
                alu_ovf    = signed_ovf(opa[MSB], ~opb[MSB], diff[MSB]);
            end
            OP_AND:   alu_result = opa & opb;
            OP_OR:    alu_result = opa | opb;
            OP_XOR:   alu_result = opa ^ opb;
            OP_SLT:   alu_result = (opa < opb) ? DATA_W'(1) : '0;
            OP_PASSB: alu_result = opb;
            default:  alu_result = '0;
        endcase
    end

    // Destination and write enable of a multiply are captured at accept so
    // upstream is free to change the bundle while the multiplier runs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_dest  <= '0;
            mul_wr_en <= 1'b0;
        end else if (mul_start) begin
            mul_dest  <= dest;
            mul_wr_en <= wr_en_in;
        end
    end

    // A pending strobe moves its result to the outputs on the following
    // edge; a new result may be produced on that same edge, giving
    // back-to-back strobes. alu_fire and mul_done are mutually exclusive
    // because nothing is accepted while the multiplier runs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RegWrite   <= 1'b0;
            res_q      <= '0;
            dest_q     <= '0;
            write_reg  <= '0;
            write_data <= '0;
            flag_z     <= 1'b0;
            flag_v     <= 1'b0;
        end else begin
            if (RegWrite) begin
                write_reg  <= dest_q;
                write_data <= res_q;
            end
            RegWrite <= 1'b0;
            if (alu_fire) begin
                res_q    <= alu_result;
                dest_q   <= dest;
                RegWrite <= wr_en_in;
                flag_z   <= (alu_result == '0);
                flag_v   <= alu_ovf;
            end else if (mul_done) begin
                res_q    <= mul_product;
                dest_q   <= mul_dest;
                RegWrite <= mul_wr_en;
                flag_z   <= (mul_product == '0);
                flag_v   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage
// Self-checking bench for alu_exec_stage: directed scenarios with constant
// expectations plus a randomized run checked cycle by cycle against a
// behavioural model built from integer arithmetic and a cycle countdown.
module tb_alu_exec_stage;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [2:0] dest;
    logic       wr_en_in;
    logic       RegWrite;
    logic [2:0] write_reg;
    logic [7:0] write_data;
    logic       flag_z;
    logic       flag_v;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Model state: what the outputs should be after the most recent edge.
    logic       m_regwrite;
    logic [2:0] m_wreg;
    logic [7:0] m_wdata;
    logic       m_z;
    logic       m_v;
    logic       m_ready;
    logic [2:0] m_pend_dest;
    logic [7:0] m_pend_data;
    int         m_mul_left;
    logic [7:0] m_mul_res;
    logic [2:0] m_mul_dest;
    logic       m_mul_wr;

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .opa        (opa),
        .opb        (opb),
        .dest       (dest),
        .wr_en_in   (wr_en_in),
        .RegWrite   (RegWrite),
        .write_reg  (write_reg),
        .write_data (write_data),
        .flag_z     (flag_z),
        .flag_v     (flag_v),
        .busy       (busy)
    );

    function automatic void ref_alu(input logic [2:0] o, input logic [7:0] a,
                                    input logic [7:0] b, output logic [7:0] r,
                                    output logic v);
        int sa;
        int sb;
        int t;
        sa = int'($signed(a));
        sb = int'($signed(b));
        v  = 1'b0;
        r  = 8'd0;
        case (o)
            3'd0: begin t = sa + sb; v = (t > 127) || (t < -128); r = 8'(t); end
            3'd1: begin t = sa - sb; v = (t > 127) || (t < -128); r = 8'(t); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sa < sb) ? 8'd1 : 8'd0;
            3'd6: begin t = sa * sb; r = 8'(t); end
            default: r = b;
        endcase
    endfunction

    task automatic model_reset();
        m_regwrite  = 1'b0;
        m_wreg      = 3'd0;
        m_wdata     = 8'd0;
        m_z         = 1'b0;
        m_v         = 1'b0;
        m_ready     = 1'b1;
        m_pend_dest = 3'd0;
        m_pend_data = 8'd0;
        m_mul_left  = 0;
        m_mul_res   = 8'd0;
        m_mul_dest  = 3'd0;
        m_mul_wr    = 1'b0;
    endtask

    // Advances the model across one rising edge using the inputs currently
    // being driven.
    task automatic model_edge();
        logic       produce;
        logic [7:0] r;
        logic       v;
        logic [2:0] pd;
        logic       pw;
        produce = 1'b0;
        r  = 8'd0;
        v  = 1'b0;
        pd = 3'd0;
        pw = 1'b0;
        if (m_regwrite) begin
            m_wreg  = m_pend_dest;
            m_wdata = m_pend_data;
        end
        m_regwrite = 1'b0;
        if (in_valid && m_ready && op != 3'd6) begin
            ref_alu(op, opa, opb, r, v);
            produce = 1'b1;
            pd = dest;
            pw = wr_en_in;
        end else if (in_valid && m_ready) begin
            ref_alu(op, opa, opb, m_mul_res, v);
            m_mul_left = 8;
            m_mul_dest = dest;
            m_mul_wr   = wr_en_in;
        end else if (m_mul_left > 0) begin
            m_mul_left = m_mul_left - 1;
            if (m_mul_left == 0) begin
                produce = 1'b1;
                r  = m_mul_res;
                v  = 1'b0;
                pd = m_mul_dest;
                pw = m_mul_wr;
            end
        end
        if (produce) begin
            m_z         = (r == 8'd0);
            m_v         = v;
            m_regwrite  = pw;
            m_pend_dest = pd;
            m_pend_data = r;
        end
        m_ready = (m_mul_left == 0);
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] d, input logic w);
        in_valid = v;
        op       = o;
        opa      = a;
        opb      = b;
        dest     = d;
        wr_en_in = w;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 3'd0, 8'd0, 8'd0, 3'd0, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({RegWrite, write_reg, write_data, flag_z, flag_v} !== 14'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%0h exp=0", {RegWrite, write_reg, write_data, flag_z, flag_v});
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready got=%0b/%0b exp=1/0", in_ready, busy);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (RegWrite !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release got=%0b/%0b exp=0/1", RegWrite, in_ready);
        end
    endtask

    task automatic test_add_sub();
        drive(1'b1, 3'd0, 8'd100, 8'd27, 3'd3, 1'b1);
        tick();
        checks++;
        if (RegWrite !== 1'b1 || flag_v !== 1'b0 || flag_z !== 1'b0) begin
            failures++;
            $display("[TB] FAIL add127_strobe got rw=%0b v=%0b z=%0b exp 1 0 0", RegWrite, flag_v, flag_z);
        end
        drive(1'b0, 3'd0, 8'd0, 8'd0, 3'd0, 1'b0);
        tick();
        checks++;
        if (RegWrite !== 1'b0 || write_reg !== 3'd3 || write_data !== 8'd127) begin
            failures++;
            $display("[TB] FAIL add127_wb got rw=%0b reg=%0d data=%0h exp 0 3 7f", RegWrite, write_reg, write_data);
        end
        drive(1'b1, 3'd0, 8'd100, 8'd28, 3'd6, 1'b1);
        tick();
        checks++;
        if (flag_v !== 1'b1 || RegWrite !== 1'b1) begin
            failures++;
            $display("[TB] FAIL add_ovf_flag got v=%0b rw=%0b exp 1 1", flag_v, RegWrite);
        end
        drive(1'b0, 3'd0, 8'd0, 8'd0, 3'd0, 1'b0);
        tick();
        checks++;
        if (write_reg !== 3'd6 || write_data !== 8'h80) begin
            failures++;
            $display("[TB] FAIL add_ovf_wb got reg=%0d data=%0h exp 6 80", write_reg, write_data);
        end
        drive(1'b1, 3'd1, 8'd5, 8'd5, 3'd2, 1'b1);
        tick();
        checks++;
        if (flag_z !== 1'b1 || flag_v !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sub_zero_flags got z=%0b v=%0b exp 1 0", flag_z, flag_v);
        end
        drive(1'b0, 3'd0, 8'd0, 8'd0, 3'd0, 1'b0);
        tick();
        checks++;
        if (write_reg !== 3'd2 || write_data !== 8'd0) begin
            failures++;
            $display("[TB] FAIL sub_zero_wb got reg=%0d data=%0h exp 2 0", write_reg, write_data);
        end
        // Flags-only instruction: OR result 0x5a, no write-back.
        drive(1'b1, 3'd3, 8'h50, 8'h0A, 3'd7, 1'b0);
        tick();
        checks++;
        if (RegWrite !== 1'b0 || flag_z !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nowr_flags got rw=%0b z=%0b exp 0 0", RegWrite, flag_z);
        end
        drive(1'b0, 3'd0, 8'd0, 8'd0, 3'd0, 1'b0);
        tick();
        checks++;
        if (write_reg !== 3'd2 || write_data !== 8'd0) begin
            failures++;
            $display("[TB] FAIL nowr_hold got reg=%0d data=%0h exp 2 0", write_reg, write_data);
        end
    endtask

    task automatic test_mul();
        int low_cycles;
        int pulses;
        low_cycles = 0;
        pulses     = 0;
        drive(1'b1, 3'd6, 8'hF9, 8'd9, 3'd5, 1'b1);
        tick();
        drive(1'b0, 3'd0, 8'd0, 8'd0, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (in_ready === 1'b0 && busy === 1'b1) low_cycles++;
            if (RegWrite === 1'b1) pulses++;
            if (i < 7) tick();
        end
        checks++;
        if (low_cycles != 8 || pulses != 0) begin
            failures++;
            $display("[TB] FAIL mul_busy_window got low=%0d pulses=%0d exp 8 0", low_cycles, pulses);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b1 || in_ready !== 1'b1 || flag_z !== 1'b0 || flag_v !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mul_done got rw=%0b rdy=%0b z=%0b v=%0b exp 1 1 0 0", RegWrite, in_ready, flag_z, flag_v);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b0 || write_reg !== 3'd5 || write_data !== 8'hC1) begin
            failures++;
            $display("[TB] FAIL mul_neg_wb got rw=%0b reg=%0d data=%0h exp 0 5 c1", RegWrite, write_reg, write_data);
        end
        // 16*16 with in_valid held high through the busy window.
        pulses = 0;
        drive(1'b1, 3'd6, 8'd16, 8'd16, 3'd7, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (RegWrite === 1'b1) pulses++;
        end
        tick();
        checks++;
        if (RegWrite !== 1'b1 || flag_z !== 1'b1 || in_ready !== 1'b1 || pulses != 0) begin
            failures++;
            $display("[TB] FAIL mul_wrap_done got rw=%0b z=%0b rdy=%0b early=%0d exp 1 1 1 0", RegWrite, flag_z, in_ready, pulses);
        end
        drive(1'b0, 3'd0, 8'd0, 8'd0, 3'd0, 1'b0);
        tick();
        checks++;
        if (write_reg !== 3'd7 || write_data !== 8'd0 || RegWrite !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mul_wrap_wb got reg=%0d data=%0h rw=%0b rdy=%0b exp 7 0 0 1", write_reg, write_data, RegWrite, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 3'd0, 8'd10, 8'd20, 3'd1, 1'b1);
        tick();
        checks++;
        if (RegWrite !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_pulse1 got=%0b exp=1", RegWrite);
        end
        drive(1'b1, 3'd4, 8'h0F, 8'h3C, 3'd2, 1'b1);
        tick();
        checks++;
        if (RegWrite !== 1'b1 || write_reg !== 3'd1 || write_data !== 8'd30) begin
            failures++;
            $display("[TB] FAIL b2b_pair1 got rw=%0b reg=%0d data=%0h exp 1 1 1e", RegWrite, write_reg, write_data);
        end
        drive(1'b1, 3'd5, 8'hFD, 8'd2, 3'd4, 1'b1);
        tick();
        checks++;
        if (RegWrite !== 1'b1 || write_reg !== 3'd2 || write_data !== 8'h33) begin
            failures++;
            $display("[TB] FAIL b2b_pair2 got rw=%0b reg=%0d data=%0h exp 1 2 33", RegWrite, write_reg, write_data);
        end
        drive(1'b0, 3'd0, 8'd0, 8'd0, 3'd0, 1'b0);
        tick();
        checks++;
        if (RegWrite !== 1'b0 || write_reg !== 3'd4 || write_data !== 8'd1) begin
            failures++;
            $display("[TB] FAIL b2b_pair3 got rw=%0b reg=%0d data=%0h exp 0 4 1", RegWrite, write_reg, write_data);
        end
    endtask

    task automatic test_reset_mid_mul();
        int bad;
        bad = 0;
        drive(1'b1, 3'd6, 8'd3, 8'd5, 3'd6, 1'b1);
        tick();
        drive(1'b0, 3'd0, 8'd0, 8'd0, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({RegWrite, write_reg, write_data, flag_z, flag_v} !== 14'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midmul_reset got=%0h rdy=%0b exp 0 1", {RegWrite, write_reg, write_data, flag_z, flag_v}, in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (RegWrite !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL midmul_after got bad_cycles=%0d exp 0", bad);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if (!(in_valid && !m_ready)) begin
                drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                      8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) != 0));
            end
            tick();
            checks++;
            if (in_ready !== m_ready || busy !== ~m_ready || RegWrite !== m_regwrite) begin
                failures++;
                $display("[TB] FAIL rand_ctrl cyc=%0d got rdy=%0b busy=%0b rw=%0b exp %0b %0b %0b", i, in_ready, busy, RegWrite, m_ready, ~m_ready, m_regwrite);
            end
            checks++;
            if (write_reg !== m_wreg || write_data !== m_wdata) begin
                failures++;
                $display("[TB] FAIL rand_wb cyc=%0d got reg=%0d data=%0h exp %0d %0h", i, write_reg, write_data, m_wreg, m_wdata);
            end
            checks++;
            if (flag_z !== m_z || flag_v !== m_v) begin
                failures++;
                $display("[TB] FAIL rand_flags cyc=%0d got z=%0b v=%0b exp %0b %0b", i, flag_z, flag_v, m_z, m_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
